// File: rtl/sa_pkg.sv
// Shared widths, grid dimensions and mode encoding for the systolic compute grid.
package sa_pkg;

    localparam int unsigned SA_ADD_DATAWIDTH = 8;
    localparam int unsigned SA_MUL_DATAWIDTH = 8;
    localparam int unsigned SA_NUM_ROWS      = 4;
    localparam int unsigned SA_NUM_COLS      = 4;

    typedef enum logic {
        MODE_PRELOAD = 1'b0,
        MODE_COMPUTE = 1'b1
    } sa_mode_e;

endpackage

// File: rtl/sa_pe.sv
// Weight-stationary processing element: holds a weight, forwards the activation east and
// the multiply-accumulated partial sum south.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned ADD_DATAWIDTH = SA_ADD_DATAWIDTH,
    parameter int unsigned MUL_DATAWIDTH = SA_MUL_DATAWIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  sa_mode_e                 mode_i,
    input  logic [MUL_DATAWIDTH-1:0] weight_i,
    input  logic [MUL_DATAWIDTH-1:0] act_i,
    input  logic [ADD_DATAWIDTH-1:0] psum_i,
    output logic [MUL_DATAWIDTH-1:0] weight_o,
    output logic [MUL_DATAWIDTH-1:0] act_o,
    output logic [ADD_DATAWIDTH-1:0] psum_o
);

    logic [MUL_DATAWIDTH-1:0] weight_r, weight_d;
    logic [MUL_DATAWIDTH-1:0] act_r, act_d;
    logic [ADD_DATAWIDTH-1:0] psum_r, psum_d;
    logic [ADD_DATAWIDTH-1:0] prod;

    // Operands widened/truncated to the adder width so the product wraps modulo 2^ADD.
    assign prod = ADD_DATAWIDTH'(act_i) * ADD_DATAWIDTH'(weight_r);

    always_comb begin
        weight_d = weight_r;
        act_d    = act_r;
        psum_d   = psum_r;
        if (mode_i == MODE_COMPUTE) begin
            act_d  = act_i;
            psum_d = psum_i + prod;
        end else begin
            weight_d = weight_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            weight_r <= '0;
            act_r    <= '0;
            psum_r   <= '0;
        end else begin
            weight_r <= weight_d;
            act_r    <= act_d;
            psum_r   <= psum_d;
        end
    end

    assign weight_o = weight_r;
    assign act_o    = act_r;
    assign psum_o   = psum_r;

endmodule

// File: rtl/sa_compute.sv
// NUM_ROWS x NUM_COLS weight-stationary systolic grid: activations flow east, weights and
// partial sums flow south, bottom-row psums leave as o_psum.
module sa_compute
    import sa_pkg::*;
#(
    parameter int unsigned ADD_DATAWIDTH = SA_ADD_DATAWIDTH,
    parameter int unsigned MUL_DATAWIDTH = SA_MUL_DATAWIDTH,
    parameter int unsigned NUM_ROWS      = SA_NUM_ROWS,
    parameter int unsigned NUM_COLS      = SA_NUM_COLS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_mode,
    input  logic                     i_load_psum,
    input  logic [MUL_DATAWIDTH-1:0] i_act    [NUM_ROWS],
    input  logic [MUL_DATAWIDTH-1:0] i_weight [NUM_COLS],
    input  logic [ADD_DATAWIDTH-1:0] i_psum   [NUM_COLS],
    output logic [ADD_DATAWIDTH-1:0] o_psum   [NUM_COLS]
);

    sa_mode_e mode;
    assign mode = sa_mode_e'(i_mode);

    logic [MUL_DATAWIDTH-1:0] weight_grid [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0] act_grid    [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0] psum_grid   [NUM_ROWS][NUM_COLS];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : row_coord
        for (genvar c = 0; c < NUM_COLS; c++) begin : col_coord
            logic [MUL_DATAWIDTH-1:0] weight_in;
            logic [MUL_DATAWIDTH-1:0] act_in;
            logic [ADD_DATAWIDTH-1:0] psum_in;

            // The north port doubles as a weight source when i_load_psum is set in pre-load.
            if (r == 0) begin : g_north
                assign weight_in = i_load_psum ? MUL_DATAWIDTH'(i_psum[c]) : i_weight[c];
                assign psum_in   = i_load_psum ? i_psum[c] : '0;
            end else begin : g_inner
                assign weight_in = weight_grid[r-1][c];
                assign psum_in   = psum_grid[r-1][c];
            end

            if (c == 0) begin : g_west
                assign act_in = i_act[r];
            end else begin : g_east
                assign act_in = act_grid[r][c-1];
            end

            sa_pe #(
                .ADD_DATAWIDTH(ADD_DATAWIDTH),
                .MUL_DATAWIDTH(MUL_DATAWIDTH)
            ) sa_pe_inst (
                .clk_i   (clk),
                .rst_i   (rst_n),
                .mode_i  (mode),
                .weight_i(weight_in),
                .act_i   (act_in),
                .psum_i  (psum_in),
                .weight_o(weight_grid[r][c]),
                .act_o   (act_grid[r][c]),
                .psum_o  (psum_grid[r][c])
            );
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_south
        assign o_psum[c] = psum_grid[NUM_ROWS-1][c];
    end

endmodule

// File: tb/tb_sa_compute.sv
// Directed self-checking bench for sa_compute with hand-derived expectations.
module tb_sa_compute;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int MW = 8;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          i_mode;
    logic          i_load_psum;
    logic [MW-1:0] i_act    [R];
    logic [MW-1:0] i_weight [C];
    logic [AW-1:0] i_psum   [C];
    logic [AW-1:0] o_psum   [C];

    logic [MW-1:0] tb_w [R][C];
    logic [MW-1:0] tb_a [R][C];
    logic [AW-1:0] tb_p [R][C];
    logic [MW-1:0] wl   [R][C];

    int tests;
    int fails;

    sa_compute #(
        .ADD_DATAWIDTH(AW),
        .MUL_DATAWIDTH(MW),
        .NUM_ROWS     (R),
        .NUM_COLS     (C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mode     (i_mode),
        .i_load_psum(i_load_psum),
        .i_act      (i_act),
        .i_weight   (i_weight),
        .i_psum     (i_psum),
        .o_psum     (o_psum)
    );

    for (genvar r = 0; r < R; r++) begin : g_r
        for (genvar c = 0; c < C; c++) begin : g_c
            assign tb_w[r][c] = dut.row_coord[r].col_coord[c].sa_pe_inst.weight_r;
            assign tb_a[r][c] = dut.row_coord[r].col_coord[c].sa_pe_inst.act_r;
            assign tb_p[r][c] = dut.row_coord[r].col_coord[c].sa_pe_inst.psum_r;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_load_psum = 1'b0;
        for (int r = 0; r < R; r++) i_act[r] = '0;
        for (int c = 0; c < C; c++) begin
            i_weight[c] = '0;
            i_psum[c]   = '0;
        end
    endtask

    // Shifts wl in from the north, last row first, so wl[r] lands in row r.
    task automatic preload();
        i_mode      = 1'b0;
        i_load_psum = 1'b0;
        for (int r = R - 1; r >= 0; r--) begin
            for (int c = 0; c < C; c++) i_weight[c] = wl[r][c];
            step();
        end
        for (int c = 0; c < C; c++) i_weight[c] = '0;
    endtask

    task automatic check_weights(input string tag);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                chk($sformatf("%s_w%0d%0d", tag, r, c), 32'(tb_w[r][c]), 32'(wl[r][c]));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset with random inputs
        rst_n       = 1'b1;
        i_mode      = 1'($urandom);
        i_load_psum = 1'($urandom);
        for (int r = 0; r < R; r++) i_act[r] = MW'($urandom);
        for (int c = 0; c < C; c++) begin
            i_weight[c] = MW'($urandom);
            i_psum[c]   = AW'($urandom);
        end
        step();
        step();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                chk($sformatf("rst_w%0d%0d", r, c), 32'(tb_w[r][c]), 32'd0);
        for (int c = 0; c < C; c++) chk($sformatf("rst_out%0d", c), 32'(o_psum[c]), 32'd0);

        rst_n  = 1'b0;
        i_mode = 1'b1;
        clear_inputs();
        for (int j = 0; j < 3; j++) begin
            step();
            for (int c = 0; c < C; c++)
                chk($sformatf("post_rst_out%0d_%0d", c, j), 32'(o_psum[c]), 32'd0);
        end

        // Pre-load of random buffer rows
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wl[r][c] = MW'($urandom_range(1, 32));
        preload();
        check_weights("pre");

        // Single activation through row 0 with W[r][c] = r+c+1
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wl[r][c] = MW'(r + c + 1);
        preload();
        check_weights("pre2");
        i_mode   = 1'b1;
        i_act[0] = 8'd2;
        step();
        i_act[0] = 8'd0;
        for (int j = 0; j < 9; j++) begin
            for (int c = 0; c < C; c++)
                chk($sformatf("single_out%0d_e%0d", c, j), 32'(o_psum[c]),
                    (j == c + 3) ? 32'(2 * (c + 1)) : 32'd0);
            step();
        end

        // North psum injection with zero weights
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wl[r][c] = '0;
        preload();
        i_mode      = 1'b1;
        i_load_psum = 1'b1;
        for (int c = 0; c < C; c++) i_psum[c] = AW'(10 * c + 1);
        step();
        i_load_psum = 1'b0;
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < C; c++)
                chk($sformatf("inject_out%0d_e%0d", c, j), 32'(o_psum[c]),
                    (j == 3) ? 32'(10 * c + 1) : 32'd0);
            step();
        end
        clear_inputs();

        // Modulo wrap: 1 + 17*15 = 256 -> 0, then 1 + 3*15 = 46
        wl[0][0] = 8'd15;
        preload();
        i_mode      = 1'b1;
        i_load_psum = 1'b1;
        i_act[0]    = 8'd17;
        i_psum[0]   = 8'd1;
        step();
        chk("wrap_pe", 32'(tb_p[0][0]), 32'd0);
        i_act[0] = 8'd3;
        step();
        chk("nowrap_pe", 32'(tb_p[0][0]), 32'd46);
        clear_inputs();
        step();
        step();
        chk("wrap_out", 32'(o_psum[0]), 32'd0);
        step();
        chk("nowrap_out", 32'(o_psum[0]), 32'd46);

        // Reset during streaming
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wl[r][c] = MW'(r + c + 1);
        preload();
        i_mode = 1'b1;
        for (int r = 0; r < R; r++) i_act[r] = MW'(r + 1);
        step();
        step();
        step();
        chk("stream_p00", 32'(tb_p[0][0]), 32'd1);
        chk("stream_a10", 32'(tb_a[1][0]), 32'd2);
        #2;
        rst_n = 1'b1;
        #1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                chk($sformatf("midrst_w%0d%0d", r, c), 32'(tb_w[r][c]), 32'd0);
                chk($sformatf("midrst_a%0d%0d", r, c), 32'(tb_a[r][c]), 32'd0);
                chk($sformatf("midrst_p%0d%0d", r, c), 32'(tb_p[r][c]), 32'd0);
            end
        for (int c = 0; c < C; c++) chk($sformatf("midrst_out%0d", c), 32'(o_psum[c]), 32'd0);
        step();
        rst_n = 1'b0;
        for (int r = 0; r < R; r++) i_act[r] = '0;
        for (int j = 0; j < 5; j++) begin
            step();
            for (int c = 0; c < C; c++)
                chk($sformatf("after_rst_out%0d_%0d", c, j), 32'(o_psum[c]), 32'd0);
        end

        // Pre-load sourced from the psum port, then from the weight port
        i_mode      = 1'b0;
        i_load_psum = 1'b1;
        for (int c = 0; c < C; c++) begin
            i_psum[c]   = AW'(c + 40);
            i_weight[c] = MW'(c + 90);
        end
        step();
        for (int c = 0; c < C; c++) chk($sformatf("psrc_w0%0d", c), 32'(tb_w[0][c]), 32'(c + 40));
        i_load_psum = 1'b0;
        step();
        for (int c = 0; c < C; c++) begin
            chk($sformatf("wsrc_w0%0d", c), 32'(tb_w[0][c]), 32'(c + 90));
            chk($sformatf("wsrc_w1%0d", c), 32'(tb_w[1][c]), 32'(c + 40));
            chk($sformatf("hold_p0%0d", c), 32'(tb_p[0][c]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
